// File: rtl/gb_pkg.sv
// Shared DMG LCD timing constants, STAT mode encoding and test-pattern helpers.
package gb_pkg;
   localparam int DOTS_PER_LINE = 456;
   localparam int LINES         = 154;
   localparam int VIS_LINES     = 144;
   localparam int VIS_W         = 160;
   localparam int OAM_DOTS      = 80;

   typedef enum logic [1:0] {HBLANK = 2'd0, VBLANK = 2'd1, OAM = 2'd2, DRAW = 2'd3} lcd_mode_t;
   typedef enum logic {IDLE = 1'b0, RUN = 1'b1} run_state_t;
   typedef enum logic [1:0] {PAT_SOLID = 2'd0, PAT_VBARS = 2'd1, PAT_HBARS = 2'd2, PAT_CHECKER = 2'd3} pattern_t;

   // 8-px wide bars: shade comes from bits [4:3] of the offset coordinate
   function automatic logic [1:0] bar_shade(input logic [7:0] coord, input logic [7:0] off);
      return 2'((coord + off) >> 3);
   endfunction
endpackage

// File: rtl/gb_lcd_timing.sv
// DMG dot/line timing generator: prescaler, counters, STAT mode decode and
// unregistered frame/line/pixel strobes derived from the current counter state.
module gb_lcd_timing
   import gb_pkg::*;
#(
   parameter int DOT_DIV   = 4,
   parameter int DRAW_DOTS = 172
)
(
   input  logic       tclk,
   input  logic       rst,
   input  logic       en,
   output logic       vs,
   output logic       hs,
   output logic       de,
   output logic       frame_end,
   output logic [7:0] line,
   output logic [7:0] x,
   output lcd_mode_t  mode
);
   localparam int PRE_W     = (DOT_DIV > 1) ? $clog2(DOT_DIV) : 1;
   localparam int PIX_START = OAM_DOTS + DRAW_DOTS - VIS_W;
   localparam int DRAW_END  = OAM_DOTS + DRAW_DOTS;

   run_state_t       state;
   logic [PRE_W-1:0] pre;
   logic [8:0]       dot;
   logic             active;
   logic             pre_last;
   logic             dot_last;
   logic             line_last;
   logic             dot_first;
   logic             visible;

   // An idle cycle with en high already counts as line 0 dot 0
   assign active    = (state == RUN) || en;
   assign pre_last  = (pre == PRE_W'(DOT_DIV - 1));
   assign dot_last  = (dot == 9'(DOTS_PER_LINE - 1));
   assign line_last = (line == 8'(LINES - 1));
   assign dot_first = active && (pre == '0) && (dot == 9'd0);
   assign visible   = (line < 8'(VIS_LINES));

   assign vs        = dot_first && (line == 8'd0);
   assign hs        = dot_first && visible;
   assign de        = active && (pre == '0) && visible &&
                      (dot >= 9'(PIX_START)) && (dot < 9'(DRAW_END));
   assign frame_end = active && pre_last && dot_last && line_last;
   assign x         = 8'(dot - 9'(PIX_START));

   always_comb begin
      mode = HBLANK;
      if (active) begin
         if (!visible)                  mode = VBLANK;
         else if (dot < 9'(OAM_DOTS))   mode = OAM;
         else if (dot < 9'(DRAW_END))   mode = DRAW;
         else                           mode = HBLANK;
      end
   end

   // Stopping is only honoured on the last tclk of a frame
   always_ff @(posedge tclk) begin
      if (rst) begin
         state <= IDLE;
         pre   <= '0;
         dot   <= '0;
         line  <= '0;
      end else if (active) begin
         state <= (frame_end && !en) ? IDLE : RUN;
         if (!pre_last) begin
            pre <= pre + 1'b1;
         end else begin
            pre <= '0;
            if (!dot_last) begin
               dot <= dot + 9'd1;
            end else begin
               dot  <= '0;
               line <= line_last ? 8'd0 : line + 8'd1;
            end
         end
      end
   end
endmodule

// File: rtl/gb_ppu_pattern_gen.sv
// Stand-alone PPU pixel stream source: DMG frame timing plus a selectable
// 2-bit test pattern, all outputs registered one tclk behind the counters.
module gb_ppu_pattern_gen
   import gb_pkg::*;
#(
   parameter int DOT_DIV   = 4,
   parameter int DRAW_DOTS = 172
)
(
   input  logic       tclk,
   input  logic       rst,
   input  logic       en,
   input  logic [1:0] pattern,
   input  logic       scroll,
   input  logic [1:0] fill,
   output logic       ppu_vs,
   output logic       ppu_hs,
   output logic       ppu_de,
   output logic [1:0] ppu_color,
   output logic [7:0] ly,
   output logic [1:0] mode,
   output logic [7:0] frame_cnt,
   output logic       frame_done
);
   logic       t_vs;
   logic       t_hs;
   logic       t_de;
   logic       t_frame_end;
   logic [7:0] t_line;
   logic [7:0] t_x;
   lcd_mode_t  t_mode;

   pattern_t   pattern_l;
   logic       scroll_l;
   logic [1:0] fill_l;
   logic [7:0] off;
   logic [1:0] color_c;

   gb_lcd_timing #(.DOT_DIV(DOT_DIV), .DRAW_DOTS(DRAW_DOTS)) u_timing (
      .tclk      (tclk),
      .rst       (rst),
      .en        (en),
      .vs        (t_vs),
      .hs        (t_hs),
      .de        (t_de),
      .frame_end (t_frame_end),
      .line      (t_line),
      .x         (t_x),
      .mode      (t_mode)
   );

   always_comb begin
      off = scroll_l ? frame_cnt : 8'd0;
      case (pattern_l)
         PAT_SOLID: color_c = fill_l;
         PAT_VBARS: color_c = bar_shade(t_x, off);
         PAT_HBARS: color_c = bar_shade(t_line, off);
         default:   color_c = {2{t_x[3] ^ t_line[3]}};
      endcase
   end

   // Pattern controls are sampled only on the frame-start cycle so a frame is never torn
   always_ff @(posedge tclk) begin
      if (rst) begin
         ppu_vs     <= 1'b0;
         ppu_hs     <= 1'b0;
         ppu_de     <= 1'b0;
         ppu_color  <= 2'd0;
         ly         <= 8'd0;
         mode       <= 2'd0;
         frame_cnt  <= 8'd0;
         frame_done <= 1'b0;
         pattern_l  <= PAT_SOLID;
         scroll_l   <= 1'b0;
         fill_l     <= 2'd0;
      end else begin
         ppu_vs     <= t_vs;
         ppu_hs     <= t_hs;
         ppu_de     <= t_de;
         ppu_color  <= t_de ? color_c : 2'd0;
         ly         <= t_line;
         mode       <= t_mode;
         frame_done <= t_frame_end;
         if (t_frame_end) frame_cnt <= frame_cnt + 8'd1;
         if (t_vs) begin
            pattern_l <= pattern_t'(pattern);
            scroll_l  <= scroll;
            fill_l    <= fill;
         end
      end
   end
endmodule

// File: tb/tb_gb_ppu_pattern_gen.sv
// Scoreboard bench: DOT_DIV=1 instance for full-frame timing/pattern checks and a
// DOT_DIV=4 instance for prescaled strobe spacing and frame-latched pattern checks.
module tb_gb_ppu_pattern_gen;
   typedef struct { int frame; int ly; int x; int color; } pix_t;
   typedef struct { int frame; int k; int ly; int mode; } tl_t;

   logic       tclk = 1'b0;
   logic       rst, en, scroll, en2, scroll2;
   logic [1:0] pattern, fill, pattern2, fill2;
   logic       vs, hs, de, frame_done, vs2, hs2, de2, frame_done2;
   logic [1:0] color, mode, color2, mode2;
   logic [7:0] ly, frame_cnt, ly2, frame_cnt2;

   pix_t pixq[$];
   pix_t pixq2[$];
   tl_t  tlq[$];
   pix_t p1, p2;
   tl_t  t1;

   int checks = 0;
   int failures = 0;
   int frame1 = 0, k1 = 0, hs_n = 0, de_n = 0, vs_n = 0, x1 = 0;
   int k2 = 0, vs2_t = 0, hs2_t = 0, de2_t = 0, x2 = 0;
   bit hs2_seen = 0;

   always #5 tclk = ~tclk;

   gb_ppu_pattern_gen #(.DOT_DIV(1), .DRAW_DOTS(172)) u_dut (
      .tclk(tclk), .rst(rst), .en(en), .pattern(pattern), .scroll(scroll), .fill(fill),
      .ppu_vs(vs), .ppu_hs(hs), .ppu_de(de), .ppu_color(color), .ly(ly), .mode(mode),
      .frame_cnt(frame_cnt), .frame_done(frame_done)
   );

   gb_ppu_pattern_gen #(.DOT_DIV(4), .DRAW_DOTS(172)) u_dut4 (
      .tclk(tclk), .rst(rst), .en(en2), .pattern(pattern2), .scroll(scroll2), .fill(fill2),
      .ppu_vs(vs2), .ppu_hs(hs2), .ppu_de(de2), .ppu_color(color2), .ly(ly2), .mode(mode2),
      .frame_cnt(frame_cnt2), .frame_done(frame_done2)
   );

   function automatic void checkOutput(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("[TB] FAIL %s actual=%0d expected=%0d", name, act, exp);
      end
   endfunction

   function automatic void checkZero(input string tag, input bit with_cnt);
      checkOutput({tag, "_vs"}, vs, 0);
      checkOutput({tag, "_hs"}, hs, 0);
      checkOutput({tag, "_de"}, de, 0);
      checkOutput({tag, "_color"}, color, 0);
      checkOutput({tag, "_ly"}, ly, 0);
      checkOutput({tag, "_mode"}, mode, 0);
      checkOutput({tag, "_frame_done"}, frame_done, 0);
      if (with_cnt) checkOutput({tag, "_frame_cnt"}, frame_cnt, 0);
   endfunction

   // Monitor for the DOT_DIV=1 instance: per-frame counts, mode timeline, pixel scoreboard
   always @(negedge tclk) begin
      if (vs) begin
         frame1++;
         k1 = 0; hs_n = 0; de_n = 0; vs_n = 0;
      end else begin
         k1++;
      end
      if (vs) vs_n++;
      if (hs) begin
         hs_n++;
         x1 = 0;
      end
      if (de) begin
         de_n++;
         if (pixq.size() > 0 && pixq[0].frame == frame1 && pixq[0].ly == int'(ly) && pixq[0].x == x1) begin
            p1 = pixq.pop_front();
            checkOutput($sformatf("pix_f%0d_y%0d_x%0d", p1.frame, p1.ly, p1.x), color, p1.color);
         end
         x1++;
      end
      if (tlq.size() > 0 && tlq[0].frame == frame1 && tlq[0].k == k1) begin
         t1 = tlq.pop_front();
         checkOutput($sformatf("ly_at_k%0d", t1.k), ly, t1.ly);
         checkOutput($sformatf("mode_at_k%0d", t1.k), mode, t1.mode);
      end
      if (frame_done) begin
         checkOutput("frame_len", k1, 70223);
         checkOutput("vs_per_frame", vs_n, 1);
         checkOutput("hs_per_frame", hs_n, 144);
         checkOutput("de_per_frame", de_n, 23040);
         checkOutput("frame_cnt_at_done", frame_cnt, frame1);
      end
   end

   // Monitor for the DOT_DIV=4 instance
   always @(negedge tclk) begin
      k2++;
      if (vs2) vs2_t = k2;
      if (hs2) begin
         if (ly2 == 8'd1 && hs2_seen) checkOutput("hs2_period", k2 - hs2_t, 1824);
         hs2_t = k2;
         hs2_seen = 1'b1;
         x2 = 0;
      end
      if (de2) begin
         if (ly2 == 8'd0) begin
            if (x2 == 0) checkOutput("de2_first_latency", k2 - vs2_t, 368);
            else         checkOutput($sformatf("de2_spacing_x%0d", x2), k2 - de2_t, 4);
         end
         de2_t = k2;
         if (pixq2.size() > 0 && pixq2[0].ly == int'(ly2) && pixq2[0].x == x2) begin
            p2 = pixq2.pop_front();
            checkOutput($sformatf("pix2_y%0d_x%0d", p2.ly, p2.x), color2, p2.color);
         end
         x2++;
      end
   end

   task automatic waitLy(input int target);
      int n = 0;
      while (int'(ly) != target && n < 80000) begin
         @(posedge tclk); #1;
         n++;
      end
      checkOutput($sformatf("reach_ly%0d", target), ly, target);
   endtask

   task automatic applyStimulus();
      int n = 0;
      rst = 1'b1; en = 1'b0; pattern = 2'd0; scroll = 1'b0; fill = 2'd0;
      en2 = 1'b0; pattern2 = 2'd0; scroll2 = 1'b0; fill2 = 2'd0;
      repeat (3) @(posedge tclk);
      #1;
      checkZero("reset", 1'b1);
      checkOutput("reset_mode2", mode2, 0);
      checkOutput("reset_frame_cnt2", frame_cnt2, 0);
      checkOutput("reset_frame_done2", frame_done2, 0);

      // Frame 1: VBARS+scroll with frame_cnt 0; later frames hand-derived below
      pixq.push_back('{1, 0, 0, 0});
      pixq.push_back('{1, 0, 8, 1});
      pixq.push_back('{1, 0, 24, 3});
      pixq.push_back('{1, 0, 159, 3});
      pixq.push_back('{1, 6, 16, 2});
      pixq.push_back('{2, 0, 6, 0});
      pixq.push_back('{2, 0, 7, 1});
      pixq.push_back('{2, 0, 24, 3});
      pixq.push_back('{2, 0, 159, 0});
      pixq.push_back('{2, 2, 0, 0});
      pixq.push_back('{2, 2, 15, 2});
      pixq.push_back('{3, 0, 0, 2});
      pixq.push_back('{3, 0, 100, 2});
      tlq.push_back('{1, 0, 0, 2});
      tlq.push_back('{1, 79, 0, 2});
      tlq.push_back('{1, 80, 0, 3});
      tlq.push_back('{1, 251, 0, 3});
      tlq.push_back('{1, 252, 0, 0});
      tlq.push_back('{1, 455, 0, 0});
      tlq.push_back('{1, 456, 1, 2});
      tlq.push_back('{1, 65663, 143, 0});
      tlq.push_back('{1, 65664, 144, 1});
      tlq.push_back('{1, 70223, 153, 1});
      pixq2.push_back('{1, 0, 0, 0});
      pixq2.push_back('{1, 0, 8, 3});
      pixq2.push_back('{1, 8, 0, 3});
      pixq2.push_back('{1, 8, 8, 0});
      pixq2.push_back('{1, 8, 16, 3});

      rst = 1'b0; en = 1'b1; pattern = 2'd1; scroll = 1'b1; fill = 2'd2;
      en2 = 1'b1; pattern2 = 2'd3;
      @(posedge tclk); #1;
      checkOutput("vs_after_en", vs, 1);

      waitLy(5);
      pattern = 2'd3;
      waitLy(50);
      en = 1'b0;
      waitLy(100);
      pattern = 2'd1;

      while (!frame_done && n < 80000) begin
         @(posedge tclk); #1;
         n++;
      end
      checkOutput("frame_done_seen", frame_done, 1);
      @(posedge tclk); #1;
      checkZero("idle", 1'b0);
      repeat (5) @(posedge tclk);
      #1;
      checkZero("idle_hold", 1'b0);

      en = 1'b1;
      @(posedge tclk); #1;
      checkOutput("vs_after_restart", vs, 1);
      repeat (10 * 456 + 200) @(posedge tclk);
      #1;
      checkOutput("ly_before_rst", ly, 10);
      rst = 1'b1; pattern = 2'd0;
      @(posedge tclk); #1;
      checkZero("mid_rst", 1'b1);
      rst = 1'b0;
      @(posedge tclk); #1;
      checkOutput("vs_after_rst_release", vs, 1);
      repeat (300) @(posedge tclk);
      #1;

      checkOutput("pixq_left", pixq.size(), 0);
      checkOutput("tlq_left", tlq.size(), 0);
      checkOutput("pixq2_left", pixq2.size(), 0);
   endtask

   // Mid-frame pattern change on the prescaled instance must wait for the next frame
   initial begin
      int n = 0;
      #20;
      while (ly2 != 8'd2 && n < 20000) begin
         @(posedge tclk); #1;
         n++;
      end
      checkOutput("reach_ly2_dut4", ly2, 2);
      pattern2 = 2'd0;
      fill2 = 2'd1;
   end

   initial begin
      applyStimulus();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
